// File: rtl/tinyrisc_pkg.sv
// -----------------------------------------------------------------------------
// tinyrisc_pkg
// Constants shared by the tinyRISC blocks.
//   DATA_W_DEF : default register width in bits
//   ADDR_W_DEF : default register address width (DEPTH = 2**ADDR_W)
//   REG_ZERO   : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package tinyrisc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;
    localparam int REG_ZERO   = 0;

endpackage : tinyrisc_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Busy scoreboard for the register file. One bit per register records that an
// issued instruction still owes a writeback to that register.
//
// Ports:
//   clk, reset          : clock; asynchronous active-high reset clears all bits
//   wr0_en/wr0_addr     : ALU writeback, clears the busy bit of its target
//   wr1_en/wr1_addr     : load/MUL writeback, clears the busy bit of its target
//   rsv_en/rsv_addr     : issue-time reservation, sets the busy bit
//   busy_vec            : registered busy bits, bit k = register k
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import tinyrisc_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr0_en,
    input  logic [ADDR_W-1:0]      wr0_addr,
    input  logic                   wr1_en,
    input  logic [ADDR_W-1:0]      wr1_addr,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [2**ADDR_W-1:0]   busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            if ((ZERO_REG != 0) && (gi == REG_ZERO)) begin : g_zero
                // The zero register never has a pending producer.
                assign busy_next[gi] = 1'b0;
            end else begin : g_live
                logic rsv_hit;
                logic wr_hit;

                assign rsv_hit = rsv_en && (rsv_addr == ADDR_W'(gi));
                assign wr_hit  = (wr0_en && (wr0_addr == ADDR_W'(gi)))
                              || (wr1_en && (wr1_addr == ADDR_W'(gi)));

                // A new reservation supersedes the writeback of the older
                // producer landing in the same cycle.
                assign busy_next[gi] = rsv_hit ? 1'b1 :
                                       wr_hit  ? 1'b0 : busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_vec = busy_reg;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file for the tinyRISC core: NUM_RD combinational read
// ports, two write ports (wr1 wins on an address clash), optional write-to-read
// bypass, optional hardwired-zero register and an integrated busy scoreboard.
//
// Ports:
//   clk, reset            : clock; asynchronous active-high reset clears state
//   rd_addr / rd_data     : packed read addresses / data, port i at slice i
//   rd_busy               : busy bit of each read address (combinational)
//   wr0_en/addr/data      : ALU writeback port
//   wr1_en/addr/data      : load/MUL writeback port (priority over wr0)
//   rsv_en / rsv_addr     : mark a destination register busy at issue
//   busy_vec              : registered scoreboard bits
//   wr_collision          : one-cycle pulse after both write ports hit one reg
// -----------------------------------------------------------------------------
module regfile_mp
    import tinyrisc_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [2**ADDR_W-1:0]       busy_vec,
    output logic                       wr_collision
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic              wr_collision_reg;
    logic              wr0_keep;
    logic              wr1_keep;

    // Writes aimed at the hardwired-zero register are discarded.
    assign wr0_keep = wr0_en && !((ZERO_REG != 0) && (wr0_addr == ADDR_W'(REG_ZERO)));
    assign wr1_keep = wr1_en && !((ZERO_REG != 0) && (wr1_addr == ADDR_W'(REG_ZERO)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_reg[k] <= '0;
            end
            wr_collision_reg <= 1'b0;
        end else begin
            if (wr0_keep) begin
                regs_reg[wr0_addr] <= wr0_data;
            end
            // Issued after wr0 so that wr1 wins when both target one register.
            if (wr1_keep) begin
                regs_reg[wr1_addr] <= wr1_data;
            end
            // Flags the clash even on the zero register, where both are dropped.
            wr_collision_reg <= wr0_en && wr1_en && (wr0_addr == wr1_addr);
        end
    end

    assign wr_collision = wr_collision_reg;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic              hit0;
            logic              hit1;

            assign addr    = rd_addr[gi*ADDR_W +: ADDR_W];
            assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
            assign hit0    = (BYPASS != 0) && wr0_en && (wr0_addr == addr);
            assign hit1    = (BYPASS != 0) && wr1_en && (wr1_addr == addr);

            assign rd_data[gi*DATA_W +: DATA_W] = is_zero ? '0       :
                                                  hit1    ? wr1_data :
                                                  hit0    ? wr0_data :
                                                            regs_reg[addr];

            // A writeback arriving this cycle resolves the dependency early
            // when its data is forwarded; a same-cycle reservation is not seen.
            assign rd_busy[gi] = !is_zero && busy_vec[addr] && !(hit0 || hit1);
        end
    endgenerate

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Two instances share one stimulus stream: inst 0 with BYPASS=1/ZERO_REG=1,
// inst 1 with BYPASS=0/ZERO_REG=0. Each is compared every cycle against a
// behavioural array model, plus directed constant checks.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic              wr0_en, wr1_en, rsv_en;
    logic [AW-1:0]     wr0_addr, wr1_addr, rsv_addr;
    logic [DW-1:0]     wr0_data, wr1_data;

    logic [NR*DW-1:0]  rd_data_a, rd_data_b;
    logic [NR-1:0]     rd_busy_a, rd_busy_b;
    logic [DEPTH-1:0]  busy_vec_a, busy_vec_b;
    logic              coll_a, coll_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_a), .wr_collision(coll_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_b), .wr_collision(coll_b)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0]    m_mem  [2][DEPTH];
    logic [DEPTH-1:0] m_busy [2];
    logic             m_coll [2];
    bit               m_byp  [2] = '{1'b1, 1'b0};
    bit               m_zr   [2] = '{1'b1, 1'b0};

    int n_compared   = 0;
    int n_mismatched = 0;
    int txn          = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) m_mem[i][k] = '0;
            m_busy[i] = '0;
            m_coll[i] = 1'b0;
        end
    endfunction

    function automatic logic [DW-1:0] exp_data(int i, logic [AW-1:0] a);
        if (reset) return '0;
        if (m_zr[i] && a == 0) return '0;
        if (m_byp[i] && wr1_en && wr1_addr == a) return wr1_data;
        if (m_byp[i] && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[i][a];
    endfunction

    function automatic logic exp_busy(int i, logic [AW-1:0] a);
        bit written;
        written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        if (m_zr[i] && a == 0) return 1'b0;
        if (m_byp[i] && written) return 1'b0;
        return m_busy[i][a];
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            m_coll[i] = wr0_en && wr1_en && (wr0_addr == wr1_addr);
            for (int k = 0; k < DEPTH; k++) begin
                bit written;
                if (m_zr[i] && k == 0) continue;
                written = (wr0_en && wr0_addr == k) || (wr1_en && wr1_addr == k);
                if (rsv_en && rsv_addr == k) m_busy[i][k] = 1'b1;
                else if (written)            m_busy[i][k] = 1'b0;
            end
            if (wr0_en && !(m_zr[i] && wr0_addr == 0)) m_mem[i][wr0_addr] = wr0_data;
            if (wr1_en && !(m_zr[i] && wr1_addr == 0)) m_mem[i][wr1_addr] = wr1_data;
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < NR; p++) begin
                logic [AW-1:0] a;
                logic [DW-1:0] od;
                logic          ob;
                a  = rd_addr[p*AW +: AW];
                od = (i == 0) ? rd_data_a[p*DW +: DW] : rd_data_b[p*DW +: DW];
                ob = (i == 0) ? rd_busy_a[p] : rd_busy_b[p];
                chk($sformatf("t%0d i%0d rd_data%0d", txn, i, p), 32'(od), 32'(exp_data(i, a)));
                chk($sformatf("t%0d i%0d rd_busy%0d", txn, i, p), 32'(ob), 32'(exp_busy(i, a)));
            end
            chk($sformatf("t%0d i%0d busy_vec", txn, i),
                32'((i == 0) ? busy_vec_a : busy_vec_b), 32'(m_busy[i]));
            chk($sformatf("t%0d i%0d wr_collision", txn, i),
                32'((i == 0) ? coll_a : coll_b), 32'(m_coll[i]));
        end
    endtask

    // Drive one cycle's inputs (at negedge), then check outputs 1ns later.
    task automatic drive(input logic rst,
                         input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                         input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                         input logic re,  input logic [AW-1:0] ra,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        reset    = rst;
        wr0_en   = w0e; wr0_addr = w0a; wr0_data = w0d;
        wr1_en   = w1e; wr1_addr = w1a; wr1_data = w1d;
        rsv_en   = re;  rsv_addr = ra;
        rd_addr  = {r1, r0};
        if (rst) model_clear();
        #1;
        compare_all();
        $display("txn %0d: rst=%0b wr0=%0b@%0d=%h wr1=%0b@%0d=%h rsv=%0b@%0d rd=%0d,%0d -> a=%h b=%h",
                 txn, rst, w0e, w0a, w0d, w1e, w1a, w1d, re, ra, r0, r1, rd_data_a, rd_data_b);
        txn++;
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, r0, r1);
    endtask

    initial begin
        reset = 1'b1;
        wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
        wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
        wr0_data = '0; wr1_data = '0; rd_addr = '0;
        model_clear();
        @(negedge clk);
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 4'd0, 4'd1);
        edge_step();

        // Write R3, same-cycle read: forwarded on inst 0, old value on inst 1.
        drive(1'b0, 1'b1, 4'd3, 16'h1234, 1'b0, '0, '0, 1'b0, '0, 4'd3, 4'd3);
        chk("byp_same_cycle", 32'(rd_data_a[0 +: DW]), 32'h1234);
        chk("nobyp_same_cycle", 32'(rd_data_b[0 +: DW]), 32'h0000);
        edge_step();
        idle(4'd3, 4'd3);
        chk("r3_port1_a", 32'(rd_data_a[DW +: DW]), 32'h1234);
        chk("r3_port1_b", 32'(rd_data_b[DW +: DW]), 32'h1234);
        edge_step();

        // Collision on R5: wr1 wins, one-cycle pulse.
        drive(1'b0, 1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555, 1'b0, '0, 4'd5, 4'd5);
        chk("coll_byp_wr1", 32'(rd_data_a[0 +: DW]), 32'h5555);
        edge_step();
        idle(4'd5, 4'd5);
        chk("coll_pulse_a", 32'(coll_a), 32'd1);
        chk("coll_r5_b", 32'(rd_data_b[0 +: DW]), 32'h5555);
        edge_step();
        idle(4'd5, 4'd5);
        chk("coll_clear_a", 32'(coll_a), 32'd0);
        edge_step();

        // Reserve R7, writeback on wr1 next cycle.
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 4'd7, 4'd7);
        chk("rsv_not_seen", 32'(rd_busy_b[0]), 32'd0);
        edge_step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 16'h00FF, 1'b0, '0, 4'd7, 4'd7);
        chk("busy7_set", 32'(busy_vec_b[7]), 32'd1);
        chk("rd_busy_byp", 32'(rd_busy_a[0]), 32'd0);
        chk("rd_busy_nobyp", 32'(rd_busy_b[0]), 32'd1);
        edge_step();
        idle(4'd7, 4'd7);
        chk("busy7_clear", 32'(busy_vec_a[7]), 32'd0);
        edge_step();

        // Reserve and write R7 together: data stored, busy stays set.
        drive(1'b0, 1'b1, 4'd7, 16'h0011, 1'b0, '0, '0, 1'b1, 4'd7, 4'd7, 4'd7);
        edge_step();
        idle(4'd7, 4'd7);
        chk("rsv_wr_data", 32'(rd_data_b[0 +: DW]), 32'h0011);
        chk("rsv_wr_busy", 32'(busy_vec_a[7]), 32'd1);
        edge_step();

        // R0 write plus reservation.
        drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, '0, '0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("r0_byp_zero", 32'(rd_data_a[0 +: DW]), 32'h0000);
        edge_step();
        idle(4'd0, 4'd0);
        chk("r0_zero_a", 32'(rd_data_a[0 +: DW]), 32'h0000);
        chk("r0_busy_a", 32'(busy_vec_a[0]), 32'd0);
        chk("r0_val_b", 32'(rd_data_b[0 +: DW]), 32'hFFFF);
        chk("r0_busy_b", 32'(busy_vec_b[0]), 32'd1);
        edge_step();

        // Asynchronous reset with registers preloaded.
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 4'd5, 4'd3);
        chk("rst_data_a", 32'(rd_data_a), 32'd0);
        chk("rst_data_b", 32'(rd_data_b), 32'd0);
        chk("rst_busy_b", 32'(busy_vec_b), 32'd0);
        chk("rst_rdbusy_b", 32'(rd_busy_b), 32'd0);
        edge_step();

        // Randomised traffic, addresses biased low to provoke clashes.
        for (int n = 0; n < 400; n++) begin
            logic rst;
            logic [AW-1:0] a0, a1, ar;
            rst = ($urandom_range(0, 63) == 0);
            a0  = AW'($urandom_range(0, 7));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 15));
            ar  = AW'($urandom_range(0, 7));
            drive(rst,
                  !rst && ($urandom_range(0, 1) == 1), a0, DW'($urandom),
                  !rst && ($urandom_range(0, 2) == 0), a1, DW'($urandom),
                  !rst && ($urandom_range(0, 2) == 0), ar,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 15)));
            edge_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_regfile_mp
